// File: rtl/iob_fifo_tdp_be_ctrl.sv
// FIFO controller for an external true-dual-port byte-enable RAM (port A write, port B read),
// with a 2-entry prefetch buffer giving FWFT output. Optional level_o: IOB_FIFO_TDP_BE_CTRL_LEVEL_EN.
module iob_fifo_tdp_be_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  rst_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [DATA_W-1:0]     w_data_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_W-1:0]     r_data_o,
`ifdef IOB_FIFO_TDP_BE_CTRL_LEVEL_EN
  output logic [ADDR_W+1:0]     level_o,
`endif
  output logic                  ram_enA_o,
  output logic [DATA_W/8-1:0]   ram_weA_o,
  output logic [ADDR_W-1:0]     ram_addrA_o,
  output logic [DATA_W-1:0]     ram_dA_o,
  output logic                  ram_enB_o,
  output logic [DATA_W/8-1:0]   ram_weB_o,
  output logic [ADDR_W-1:0]     ram_addrB_o,
  input  logic [DATA_W-1:0]     ram_dB_i
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] wr_ptr, rd_ptr, ram_level;
  logic [ADDR_W:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic            w_ready_nxt;
  logic            inflight;
  logic [1:0]      out_cnt;
  logic            head;
  logic            tail;
  logic [DATA_W-1:0] obuf [2];
  logic            push, pop, issue;
  logic [2:0]      occ;

  assign ram_level = wr_ptr - rd_ptr;
  assign push      = w_valid_i & w_ready_o & ~rst_i;
  assign pop       = r_valid_o & r_ready_i;

  // Buffer slots already promised after this cycle: held words plus the one landing, minus the pop.
  assign occ   = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = ~rst_i & (ram_level != '0) & (occ < 3'd2);

  // Landing happens only when at most one word is held, so the tail is never the live head.
  assign tail = head ^ out_cnt[0];

  always_comb begin
    wr_ptr_nxt  = wr_ptr + {{ADDR_W{1'b0}}, push};
    rd_ptr_nxt  = rd_ptr + {{ADDR_W{1'b0}}, issue};
    level_nxt   = wr_ptr_nxt - rd_ptr_nxt;
    w_ready_nxt = (level_nxt != DEPTH) & ~rst_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      out_cnt   <= 2'd0;
      head      <= 1'b0;
      w_ready_o <= 1'b0;
      obuf[0]   <= '0;
      obuf[1]   <= '0;
    end else if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      out_cnt   <= 2'd0;
      head      <= 1'b0;
      w_ready_o <= 1'b0;
      obuf[0]   <= '0;
      obuf[1]   <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      inflight  <= issue;
      w_ready_o <= w_ready_nxt;
      out_cnt   <= out_cnt + {1'b0, inflight} - {1'b0, pop};
      if (inflight) obuf[tail] <= ram_dB_i;
      if (pop) head <= ~head;
    end
  end

  assign r_valid_o = (out_cnt != 2'd0);
  assign r_data_o  = obuf[head];

  // Address and data are gated so idle RAM ports show all zeros.
  assign ram_enA_o   = push;
  assign ram_weA_o   = {BE_W{push}};
  assign ram_addrA_o = push ? wr_ptr[ADDR_W-1:0] : '0;
  assign ram_dA_o    = push ? w_data_i : '0;
  assign ram_enB_o   = issue;
  assign ram_weB_o   = '0;
  assign ram_addrB_o = issue ? rd_ptr[ADDR_W-1:0] : '0;

`ifdef IOB_FIFO_TDP_BE_CTRL_LEVEL_EN
  assign level_o = (ADDR_W+2)'(ram_level) + (ADDR_W+2)'(inflight) + (ADDR_W+2)'(out_cnt);
`endif

endmodule
